// File: rtl/csr_commit_seq_pkg.sv
// Shared definitions for the CSR commit sequencer: CSR numbers, ESTAT
// field positions, write masks and the sequencer state encoding.
package csr_commit_seq_pkg;

   localparam logic [13:0] CSR_CRMD  = 14'h0;
   localparam logic [13:0] CSR_PRMD  = 14'h1;
   localparam logic [13:0] CSR_ESTAT = 14'h5;
   localparam logic [13:0] CSR_ERA   = 14'h6;
   localparam logic [13:0] CSR_BADV  = 14'h7;

   localparam int ESTAT_ECODE_LSB = 16;
   localparam int ESTAT_ESUB_LSB  = 22;

   localparam logic [31:0] MASK_PLV_IE = 32'h0000_0007;
   localparam logic [31:0] MASK_ESTAT  = 32'h7FFF_0000;
   localparam logic [31:0] MASK_FULL   = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_E_PRMD  = 3'd1,
      ST_E_CRMD  = 3'd2,
      ST_E_ERA   = 3'd3,
      ST_E_ESTAT = 3'd4,
      ST_E_BADV  = 3'd5,
      ST_R_CRMD  = 3'd6,
      ST_REDIR   = 3'd7
   } seq_state_e;

   // ESTAT write value: Ecode and EsubCode placed in their fields, rest zero.
   function automatic logic [31:0] estat_value(input logic [8:0] esub, input logic [5:0] ecode);
      logic [31:0] v;
      v = '0;
      v[ESTAT_ESUB_LSB +: 9]  = esub;
      v[ESTAT_ECODE_LSB +: 6] = ecode;
      return v;
   endfunction

endpackage

// File: rtl/csr_commit_seq_redirect.sv
// One-entry valid/ready output register for the fetch redirect. The target
// is captured when the sequence starts and held stable while valid is up.
module csr_commit_seq_redirect (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic        arm,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] pc
);

   // valid rises when the sequencer enters REDIR and drops on handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid <= 1'b0;
      end else if (arm) begin
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

   // target is latched only on an accepted trigger
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_pc;
      end
   end

endmodule

// File: rtl/csr_commit_seq.sv
// CSR commit sequencer: owns the CSR write port, passes CSR-instruction
// writes through in IDLE and runs the exception / ERTN write sequence
// followed by a fetch redirect.
// Optional build macro CSR_SEQ_PERF_EN enables the exc_cnt / ertn_cnt
// event counters; without it both outputs are tied to zero.
//
// state    | meaning
// IDLE     | pass CSR-instruction writes through, watch for triggers
// E_PRMD   | exception: save CRMD.PLV/IE into PRMD
// E_CRMD   | exception: clear CRMD.PLV/IE
// E_ERA    | exception: write faulting pc into ERA
// E_ESTAT  | exception: write Ecode/EsubCode into ESTAT
// E_BADV   | exception: write bad virtual address (only when flagged)
// R_CRMD   | ERTN: restore CRMD.PLV/IE from PRMD
// REDIR    | present redirect to fetch until accepted
module csr_commit_seq
   import csr_commit_seq_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int CSR_NUM_W = 14
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 wb_excp,
   input  logic                 wb_ertn,
   input  logic [31:0]          wb_pc,
   input  logic [5:0]           wb_ecode,
   input  logic [8:0]           wb_esubcode,
   input  logic                 wb_badv_we,
   input  logic [31:0]          wb_badv,
   input  logic                 inst_csr_we,
   input  logic [CSR_NUM_W-1:0] inst_csr_num,
   input  logic [31:0]          inst_csr_wval,
   input  logic [31:0]          inst_csr_wmask,
   input  logic [31:0]          crmd_q,
   input  logic [31:0]          prmd_q,
   input  logic [31:0]          era_q,
   input  logic [31:0]          eentry_q,
   output logic                 csr_we,
   output logic [CSR_NUM_W-1:0] csr_num,
   output logic [31:0]          csr_wvalue,
   output logic [31:0]          csr_wmask,
   output logic                 redirect_valid,
   output logic [31:0]          redirect_pc,
   input  logic                 redirect_ready,
   output logic                 pipe_flush,
   output logic                 seq_busy,
   output logic [CNT_W-1:0]     exc_cnt,
   output logic [CNT_W-1:0]     ertn_cnt
);

   seq_state_e  state_q, state_nxt;
   logic [31:0] pc_q, badv_q;
   logic [5:0]  ecode_q;
   logic [8:0]  esub_q;
   logic        badv_we_q;
   logic        take_excp, take_ertn, arm_redir;
   logic        unused_ok;

   // only the PLV/IE bits of CRMD and PRMD take part in the sequence
   assign unused_ok = ^{crmd_q[31:3], prmd_q[31:3]};

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_nxt;
   end

   // trigger context captured on the accepting cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q      <= '0;
         badv_q    <= '0;
         ecode_q   <= '0;
         esub_q    <= '0;
         badv_we_q <= 1'b0;
      end else if (take_excp || take_ertn) begin
         pc_q      <= wb_pc;
         badv_q    <= wb_badv;
         ecode_q   <= wb_ecode;
         esub_q    <= wb_esubcode;
         badv_we_q <= wb_badv_we;
      end
   end

   // next state, CSR write port mux, flush/busy
   always_comb begin
      state_nxt  = state_q;
      csr_we     = 1'b0;
      csr_num    = '0;
      csr_wvalue = '0;
      csr_wmask  = '0;
      pipe_flush = 1'b1;
      seq_busy   = 1'b1;
      take_excp  = 1'b0;
      take_ertn  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pipe_flush = 1'b0;
            seq_busy   = 1'b0;
            csr_we     = inst_csr_we;
            csr_num    = inst_csr_num;
            csr_wvalue = inst_csr_wval;
            csr_wmask  = inst_csr_wmask;
            // exception has priority over a simultaneous ERTN
            if (wb_excp) begin
               take_excp  = 1'b1;
               csr_we     = 1'b0;
               pipe_flush = 1'b1;
               state_nxt  = ST_E_PRMD;
            end else if (wb_ertn) begin
               take_ertn  = 1'b1;
               csr_we     = 1'b0;
               pipe_flush = 1'b1;
               state_nxt  = ST_R_CRMD;
            end
         end
         ST_E_PRMD: begin
            csr_we     = 1'b1;
            csr_num    = CSR_NUM_W'(CSR_PRMD);
            csr_wvalue = {29'b0, crmd_q[2:0]};
            csr_wmask  = MASK_PLV_IE;
            state_nxt  = ST_E_CRMD;
         end
         ST_E_CRMD: begin
            csr_we     = 1'b1;
            csr_num    = CSR_NUM_W'(CSR_CRMD);
            csr_wmask  = MASK_PLV_IE;
            state_nxt  = ST_E_ERA;
         end
         ST_E_ERA: begin
            csr_we     = 1'b1;
            csr_num    = CSR_NUM_W'(CSR_ERA);
            csr_wvalue = pc_q;
            csr_wmask  = MASK_FULL;
            state_nxt  = ST_E_ESTAT;
         end
         ST_E_ESTAT: begin
            csr_we     = 1'b1;
            csr_num    = CSR_NUM_W'(CSR_ESTAT);
            csr_wvalue = estat_value(esub_q, ecode_q);
            csr_wmask  = MASK_ESTAT;
            state_nxt  = badv_we_q ? ST_E_BADV : ST_REDIR;
         end
         ST_E_BADV: begin
            csr_we     = 1'b1;
            csr_num    = CSR_NUM_W'(CSR_BADV);
            csr_wvalue = badv_q;
            csr_wmask  = MASK_FULL;
            state_nxt  = ST_REDIR;
         end
         ST_R_CRMD: begin
            csr_we     = 1'b1;
            csr_num    = CSR_NUM_W'(CSR_CRMD);
            csr_wvalue = {29'b0, prmd_q[2:0]};
            csr_wmask  = MASK_PLV_IE;
            state_nxt  = ST_REDIR;
         end
         ST_REDIR: begin
            if (redirect_valid && redirect_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // redirect valid is raised on the same edge the FSM enters REDIR
   assign arm_redir = (state_q != ST_REDIR) && (state_nxt == ST_REDIR);

   csr_commit_seq_redirect u_redirect (
      .clk     (clk),
      .resetn  (resetn),
      .load    (take_excp || take_ertn),
      .load_pc (take_excp ? eentry_q : era_q),
      .arm     (arm_redir),
      .ready   (redirect_ready),
      .valid   (redirect_valid),
      .pc      (redirect_pc)
   );

`ifdef CSR_SEQ_PERF_EN
   // event counters, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_cnt  <= '0;
         ertn_cnt <= '0;
      end else begin
         if (take_excp) exc_cnt  <= exc_cnt + 1'b1;
         if (take_ertn) ertn_cnt <= ertn_cnt + 1'b1;
      end
   end
`else
   assign exc_cnt  = '0;
   assign ertn_cnt = '0;
`endif

endmodule

// File: tb/tb_csr_commit_seq.sv
// Directed self-checking bench for csr_commit_seq.
module tb_csr_commit_seq;

   logic        clk;
   logic        resetn;
   logic        wb_excp, wb_ertn;
   logic [31:0] wb_pc;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic        wb_badv_we;
   logic [31:0] wb_badv;
   logic        inst_csr_we;
   logic [13:0] inst_csr_num;
   logic [31:0] inst_csr_wval, inst_csr_wmask;
   logic [31:0] crmd_q, prmd_q, era_q, eentry_q;
   logic        csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wvalue, csr_wmask;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        pipe_flush, seq_busy;
   logic [31:0] exc_cnt, ertn_cnt;

   int errors = 0;
   int checks = 0;
   int exp_exc = 0;
   int exp_ertn = 0;

   csr_commit_seq #(.CNT_W(32), .CSR_NUM_W(14)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .wb_excp        (wb_excp),
      .wb_ertn        (wb_ertn),
      .wb_pc          (wb_pc),
      .wb_ecode       (wb_ecode),
      .wb_esubcode    (wb_esubcode),
      .wb_badv_we     (wb_badv_we),
      .wb_badv        (wb_badv),
      .inst_csr_we    (inst_csr_we),
      .inst_csr_num   (inst_csr_num),
      .inst_csr_wval  (inst_csr_wval),
      .inst_csr_wmask (inst_csr_wmask),
      .crmd_q         (crmd_q),
      .prmd_q         (prmd_q),
      .era_q          (era_q),
      .eentry_q       (eentry_q),
      .csr_we         (csr_we),
      .csr_num        (csr_num),
      .csr_wvalue     (csr_wvalue),
      .csr_wmask      (csr_wmask),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .pipe_flush     (pipe_flush),
      .seq_busy       (seq_busy),
      .exc_cnt        (exc_cnt),
      .ertn_cnt       (ertn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      wb_excp = 0; wb_ertn = 0; wb_pc = '0; wb_ecode = '0; wb_esubcode = '0;
      wb_badv_we = 0; wb_badv = '0; inst_csr_we = 0; inst_csr_num = '0;
      inst_csr_wval = '0; inst_csr_wmask = '0; crmd_q = '0; prmd_q = '0;
      era_q = '0; eentry_q = '0; redirect_ready = 0;
   endtask

   task automatic test_reset;
      resetn = 0;
      clear_inputs();
      tick(); tick();
      checks++;
      if ({csr_we, csr_num, csr_wvalue, csr_wmask, redirect_valid, redirect_pc, pipe_flush, seq_busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%0b num=%h val=%h mask=%h rv=%0b rpc=%h fl=%0b busy=%0b, want all 0",
                  csr_we, csr_num, csr_wvalue, csr_wmask, redirect_valid, redirect_pc, pipe_flush, seq_busy);
      end
      checks++;
      if ({exc_cnt, ertn_cnt} !== 64'h0) begin
         errors++;
         $display("FAIL reset_counters: got exc=%0d ertn=%0d want 0 0", exc_cnt, ertn_cnt);
      end
      resetn = 1;
      tick();
   endtask

   task automatic test_passthrough;
      tick();
      inst_csr_we = 1; inst_csr_num = 14'h6; inst_csr_wval = 32'h1234_5678; inst_csr_wmask = 32'hFFFF_0000;
      #1;
      checks++;
      if ({csr_we, csr_num, csr_wvalue, csr_wmask, pipe_flush, seq_busy} !== {1'b1, 14'h6, 32'h1234_5678, 32'hFFFF_0000, 2'b00}) begin
         errors++;
         $display("FAIL pass_write: got we=%0b num=%h val=%h mask=%h fl=%0b busy=%0b want 1 0006 12345678 ffff0000 0 0",
                  csr_we, csr_num, csr_wvalue, csr_wmask, pipe_flush, seq_busy);
      end
      tick();
      inst_csr_we = 0; inst_csr_num = 14'h3FFF; inst_csr_wval = 32'hA5A5_5A5A; inst_csr_wmask = 32'h0000_FFFF;
      #1;
      checks++;
      if ({csr_we, csr_num, csr_wvalue, csr_wmask} !== {1'b0, 14'h3FFF, 32'hA5A5_5A5A, 32'h0000_FFFF}) begin
         errors++;
         $display("FAIL pass_nowrite: got we=%0b num=%h val=%h mask=%h want 0 3fff a5a55a5a 0000ffff",
                  csr_we, csr_num, csr_wvalue, csr_wmask);
      end
      tick();
      clear_inputs();
   endtask

   // Entered at the first REDIR cycle (posedge+1); leaves one cycle after the handshake.
   task automatic finish_redirect(input string name, input logic [31:0] exp_pc, input int delay);
      for (int k = 0; k < delay; k++) begin
         #1;
         checks++;
         if ({redirect_valid, redirect_pc, csr_we, pipe_flush, seq_busy} !== {1'b1, exp_pc, 3'b011}) begin
            errors++;
            $display("FAIL %s redir_stall%0d: got rv=%0b pc=%h we=%0b fl=%0b busy=%0b want 1 %h 0 1 1",
                     name, k, redirect_valid, redirect_pc, csr_we, pipe_flush, seq_busy, exp_pc);
         end
         tick();
      end
      redirect_ready = 1; wb_excp = 0; wb_ertn = 0; inst_csr_we = 0;
      #1;
      checks++;
      if ({redirect_valid, redirect_pc, csr_we, pipe_flush, seq_busy} !== {1'b1, exp_pc, 3'b011}) begin
         errors++;
         $display("FAIL %s redir: got rv=%0b pc=%h we=%0b fl=%0b busy=%0b want 1 %h 0 1 1",
                  name, redirect_valid, redirect_pc, csr_we, pipe_flush, seq_busy, exp_pc);
      end
      tick();
      redirect_ready = 0;
      #1;
      checks++;
      if ({redirect_valid, pipe_flush, seq_busy, csr_we} !== 4'b0000) begin
         errors++;
         $display("FAIL %s back_idle: got rv=%0b fl=%0b busy=%0b we=%0b want 0 0 0 0",
                  name, redirect_valid, pipe_flush, seq_busy, csr_we);
      end
   endtask

   task automatic test_exception(input string name, input logic [31:0] pc, input logic [5:0] ecode,
                                 input logic [8:0] esub, input logic bw, input logic [31:0] badv,
                                 input logic [31:0] entry, input logic [31:0] crmd, input logic both,
                                 input logic pre_ready, input int delay);
      logic [13:0] en [5];
      logic [31:0] ed [5];
      logic [31:0] em [5];
      int nw;
      en = '{14'h1, 14'h0, 14'h6, 14'h5, 14'h7};
      ed = '{{29'b0, crmd[2:0]}, 32'h0, pc, {1'b0, esub, ecode, 16'h0}, badv};
      em = '{32'h7, 32'h7, 32'hFFFF_FFFF, 32'h7FFF_0000, 32'hFFFF_FFFF};
      nw = bw ? 5 : 4;
      tick();
      wb_excp = 1; wb_ertn = both; wb_pc = pc; wb_ecode = ecode; wb_esubcode = esub;
      wb_badv_we = bw; wb_badv = badv; eentry_q = entry; era_q = 32'h7777_0000; crmd_q = crmd;
      inst_csr_we = 1; inst_csr_num = 14'h6; inst_csr_wval = 32'hDEAD_BEEF; inst_csr_wmask = 32'hFFFF_FFFF;
      redirect_ready = pre_ready;
      exp_exc++;
      #1;
      checks++;
      if ({csr_we, pipe_flush, seq_busy, redirect_valid} !== 4'b0100) begin
         errors++;
         $display("FAIL %s trigger: got we=%0b fl=%0b busy=%0b rv=%0b want 0 1 0 0",
                  name, csr_we, pipe_flush, seq_busy, redirect_valid);
      end
      for (int i = 0; i < nw; i++) begin
         tick();
         if (i == 0) begin
            // context changes after the trigger must not leak into the sequence
            wb_excp = both; wb_ertn = both; wb_pc = 32'h0BAD_0BAD; wb_badv = ~badv;
            wb_badv_we = ~bw; wb_ecode = ~ecode; wb_esubcode = ~esub; eentry_q = ~entry;
         end
         #1;
         checks++;
         if ({csr_we, csr_num, csr_wvalue, csr_wmask, pipe_flush, seq_busy, redirect_valid} !==
             {1'b1, en[i], ed[i], em[i], 3'b110}) begin
            errors++;
            $display("FAIL %s write%0d: got we=%0b num=%h val=%h mask=%h fl=%0b busy=%0b rv=%0b want 1 %h %h %h 1 1 0",
                     name, i, csr_we, csr_num, csr_wvalue, csr_wmask, pipe_flush, seq_busy, redirect_valid,
                     en[i], ed[i], em[i]);
         end
      end
      tick();
      finish_redirect(name, entry, delay);
      clear_inputs();
   endtask

   task automatic test_ertn(input string name, input logic [31:0] prmd, input logic [31:0] era, input int delay);
      tick();
      wb_ertn = 1; prmd_q = prmd; era_q = era; eentry_q = 32'h1C00_8000;
      exp_ertn++;
      #1;
      checks++;
      if ({csr_we, pipe_flush, seq_busy} !== 3'b010) begin
         errors++;
         $display("FAIL %s trigger: got we=%0b fl=%0b busy=%0b want 0 1 0", name, csr_we, pipe_flush, seq_busy);
      end
      tick();
      wb_ertn = 0; era_q = 32'h0;
      #1;
      checks++;
      if ({csr_we, csr_num, csr_wvalue, csr_wmask, pipe_flush, seq_busy, redirect_valid} !==
          {1'b1, 14'h0, {29'b0, prmd[2:0]}, 32'h7, 3'b110}) begin
         errors++;
         $display("FAIL %s crmd: got we=%0b num=%h val=%h mask=%h fl=%0b busy=%0b rv=%0b want 1 0000 %h 00000007 1 1 0",
                  name, csr_we, csr_num, csr_wvalue, csr_wmask, pipe_flush, seq_busy, redirect_valid,
                  {29'b0, prmd[2:0]});
      end
      tick();
      finish_redirect(name, era, delay);
      clear_inputs();
   endtask

   task automatic test_reset_mid_seq;
      tick();
      wb_excp = 1; wb_pc = 32'h1C00_0400; wb_ecode = 6'h0B; eentry_q = 32'h1C00_8000;
      tick();
      clear_inputs();
      tick();
      tick();
      #1;
      checks++;
      if ({csr_we, csr_num, csr_wvalue} !== {1'b1, 14'h6, 32'h1C00_0400}) begin
         errors++;
         $display("FAIL mid_reset era_write: got we=%0b num=%h val=%h want 1 0006 1c000400", csr_we, csr_num, csr_wvalue);
      end
      #2;
      resetn = 0;
      exp_exc = 0; exp_ertn = 0;
      #1;
      checks++;
      if ({csr_we, csr_num, csr_wvalue, csr_wmask, redirect_valid, redirect_pc, pipe_flush, seq_busy, exc_cnt, ertn_cnt} !== '0) begin
         errors++;
         $display("FAIL mid_reset async_clear: got we=%0b num=%h val=%h mask=%h rv=%0b rpc=%h fl=%0b busy=%0b exc=%0d ertn=%0d want all 0",
                  csr_we, csr_num, csr_wvalue, csr_wmask, redirect_valid, redirect_pc, pipe_flush, seq_busy, exc_cnt, ertn_cnt);
      end
      tick();
      resetn = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({redirect_valid, seq_busy, pipe_flush} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset no_redirect%0d: got rv=%0b busy=%0b fl=%0b want 0 0 0",
                     i, redirect_valid, seq_busy, pipe_flush);
         end
      end
   endtask

   task automatic test_perf_counters;
      int want_exc, want_ertn;
      want_exc = exp_exc;
      want_ertn = exp_ertn;
`ifndef CSR_SEQ_PERF_EN
      want_exc = 0;
      want_ertn = 0;
`endif
      #1;
      checks++;
      if (exc_cnt !== 32'(want_exc)) begin
         errors++;
         $display("FAIL exc_cnt: got %0d want %0d", exc_cnt, want_exc);
      end
      checks++;
      if (ertn_cnt !== 32'(want_ertn)) begin
         errors++;
         $display("FAIL ertn_cnt: got %0d want %0d", ertn_cnt, want_ertn);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_reset_mid_seq();
      // ADEF with BADV, same-cycle CSR-instruction write to ERA must be dropped
      test_exception("adef", 32'h1C00_0100, 6'h08, 9'h0, 1'b1, 32'h1C00_0100, 32'h1C00_8000,
                     32'hFFFF_FFFB, 1'b0, 1'b0, 0);
      // SYS without BADV, fetch ready held high before valid
      test_exception("sys", 32'h1C00_0200, 6'h0B, 9'h0, 1'b0, 32'h0, 32'h1C00_9000,
                     32'h0000_0004, 1'b0, 1'b1, 0);
      test_ertn("ertn", 32'hABCD_EF07, 32'h1C00_0204, 0);
      // ERTN with fetch stalling the redirect for three cycles
      test_ertn("ertn_stall", 32'h0000_0002, 32'h1C00_0300, 3);
      // exception and ERTN together: exception wins, retriggers while busy ignored
      test_exception("both", 32'h1C00_0500, 6'h09, 9'h001, 1'b1, 32'h0000_1234, 32'h1C00_A000,
                     32'h0000_0005, 1'b1, 1'b0, 2);
      test_perf_counters();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
